// File: rtl/voice_allocator_pkg.sv
// Shared types and limits for the polyphonic voice allocator.
// Optional feature macro used by the allocator: SUSTAIN_PEDAL_EN.
package voice_allocator_pkg;

  localparam int MAX_VOICES = 16;

  typedef logic [6:0] note_t;

  typedef enum logic {
    ALLOC_IDLE,
    ALLOC_RETRIG
  } alloc_state_t;

endpackage

// File: rtl/voice_allocator_age_lru.sv
// Age permutation for the voice allocator: age 0 is the most recently allocated
// voice, VOICES-1 the oldest. Ages are registered; the oldest pick is combinational.
module voice_age_lru
  import voice_allocator_pkg::*;
#(
  parameter int VOICES = 4,
  parameter int IW     = $clog2(VOICES)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_touch,
  input  logic [IW-1:0]     i_idx,
  input  logic [VOICES-1:0] i_pref,
  output logic [IW-1:0]     o_oldest
);

  logic [IW-1:0] r_age [VOICES];
  logic          w_pref_found;
  logic [IW-1:0] w_pref_idx;
  logic [IW-1:0] w_pref_age;
  logic [IW-1:0] w_lru_idx;

  // Age update: touched voice becomes youngest, everything younger than it ages by one.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int v = 0; v < VOICES; v++) begin
        r_age[v] <= IW'(v);
      end
    end else if (i_touch) begin
      for (int v = 0; v < VOICES; v++) begin
        if (IW'(v) == i_idx) begin
          r_age[v] <= '0;
        end else if (r_age[v] < r_age[i_idx]) begin
          r_age[v] <= r_age[v] + IW'(1'b1);
        end else begin
          r_age[v] <= r_age[v];
        end
      end
    end else begin
      for (int v = 0; v < VOICES; v++) begin
        r_age[v] <= r_age[v];
      end
    end
  end

  // Oldest voice overall, or the oldest among the preferred set when that set is non-empty.
  always_comb begin
    w_lru_idx    = '0;
    w_pref_found = 1'b0;
    w_pref_idx   = '0;
    w_pref_age   = '0;
    for (int v = 0; v < VOICES; v++) begin
      if (r_age[v] == IW'(VOICES - 1)) begin
        w_lru_idx = IW'(v);
      end else begin
        w_lru_idx = w_lru_idx;
      end
      if (i_pref[v] && (!w_pref_found || (r_age[v] > w_pref_age))) begin
        w_pref_found = 1'b1;
        w_pref_idx   = IW'(v);
        w_pref_age   = r_age[v];
      end else begin
        w_pref_found = w_pref_found;
      end
    end
    if (w_pref_found) begin
      o_oldest = w_pref_idx;
    end else begin
      o_oldest = w_lru_idx;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic note-to-voice allocator driving adsr gates and per-voice note numbers.
// Define SUSTAIN_PEDAL_EN to add the sustain pedal input and sustained-voice handling.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int VOICES    = 4,
  parameter int NOTE_BITS = 7
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_ev_valid,
  output logic                        o_ev_ready,
  input  logic                        i_ev_note_on,
  input  logic [NOTE_BITS-1:0]        i_ev_note,
  input  logic [VOICES-1:0]           i_active,
  output logic [VOICES-1:0]           o_gate,
  output logic [VOICES*NOTE_BITS-1:0] o_voice_note
`ifdef SUSTAIN_PEDAL_EN
  ,
  input  logic                        i_sustain
`endif
);

  localparam int IW = $clog2(VOICES);

  alloc_state_t         r_state;
  logic                 r_ev_ready;
  logic [VOICES-1:0]    r_gate;
  logic [NOTE_BITS-1:0] r_note [VOICES];
  logic [IW-1:0]        r_victim;

  logic                 w_accept;
  logic                 w_on_acc;
  logic                 w_off_acc;
  logic                 w_hit_found;
  logic [IW-1:0]        w_hit_idx;
  logic                 w_free_found;
  logic [IW-1:0]        w_free_idx;
  logic                 w_rel_found;
  logic [IW-1:0]        w_rel_idx;
  logic [VOICES-1:0]    w_off_mask;
  logic [IW-1:0]        w_oldest;
  logic [IW-1:0]        w_alloc_idx;
  logic                 w_alloc_two;
  logic [VOICES-1:0]    w_gate_nxt;
  logic [VOICES-1:0]    w_pref;

`ifdef SUSTAIN_PEDAL_EN
  logic                 r_sus_d;
  logic [VOICES-1:0]    r_sus;
  logic [VOICES-1:0]    w_sus_nxt;
  logic                 w_sus_fall;
  assign w_sus_fall = r_sus_d && !i_sustain;
  assign w_pref     = r_sus;
`else
  assign w_pref     = '0;
`endif

  assign w_accept  = i_ev_valid && r_ev_ready;
  assign w_on_acc  = w_accept && i_ev_note_on;
  assign w_off_acc = w_accept && !i_ev_note_on;

  assign o_ev_ready = r_ev_ready;
  assign o_gate     = r_gate;

  for (genvar g = 0; g < VOICES; g++) begin : g_note_out
    assign o_voice_note[g*NOTE_BITS +: NOTE_BITS] = r_note[g];
  end

  voice_age_lru #(
    .VOICES (VOICES),
    .IW     (IW)
  ) u_age (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_touch  (w_on_acc),
    .i_idx    (w_alloc_idx),
    .i_pref   (w_pref),
    .o_oldest (w_oldest)
  );

  // Priority encoders; scanning downward leaves the lowest matching index.
  always_comb begin
    w_hit_found  = 1'b0;
    w_hit_idx    = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_rel_found  = 1'b0;
    w_rel_idx    = '0;
    w_off_mask   = '0;
    for (int v = VOICES - 1; v >= 0; v--) begin
      if (r_gate[v]) begin
        if (r_note[v] == i_ev_note) begin
          w_hit_found   = 1'b1;
          w_hit_idx     = IW'(v);
          w_off_mask[v] = 1'b1;
        end else begin
          w_off_mask[v] = 1'b0;
        end
      end else begin
        w_rel_found = 1'b1;
        w_rel_idx   = IW'(v);
        if (!i_active[v]) begin
          w_free_found = 1'b1;
          w_free_idx   = IW'(v);
        end else begin
          w_free_found = w_free_found;
        end
      end
    end
    if (w_hit_found) begin
      w_alloc_idx = w_hit_idx;
      w_alloc_two = 1'b1;
    end else if (w_free_found) begin
      w_alloc_idx = w_free_idx;
      w_alloc_two = 1'b0;
    end else if (w_rel_found) begin
      w_alloc_idx = w_rel_idx;
      w_alloc_two = 1'b0;
    end else begin
      w_alloc_idx = w_oldest;
      w_alloc_two = 1'b1;
    end
  end

  // Next gate vector; a retrigger/steal drops the gate for exactly one cycle.
  always_comb begin
    w_gate_nxt = r_gate;
`ifdef SUSTAIN_PEDAL_EN
    w_sus_nxt = r_sus;
    if (w_sus_fall) begin
      w_gate_nxt = w_gate_nxt & ~r_sus;
      w_sus_nxt  = '0;
    end else begin
      w_sus_nxt  = r_sus;
    end
`endif
    case (r_state)
      ALLOC_IDLE: begin
        if (w_on_acc) begin
          w_gate_nxt[w_alloc_idx] = !w_alloc_two;
`ifdef SUSTAIN_PEDAL_EN
          w_sus_nxt[w_alloc_idx]  = 1'b0;
`endif
        end else if (w_off_acc) begin
`ifdef SUSTAIN_PEDAL_EN
          if (i_sustain) begin
            w_sus_nxt = w_sus_nxt | w_off_mask;
          end else begin
            w_gate_nxt = w_gate_nxt & ~w_off_mask;
          end
`else
          w_gate_nxt = w_gate_nxt & ~w_off_mask;
`endif
        end else begin
          w_gate_nxt = w_gate_nxt;
        end
      end
      ALLOC_RETRIG: w_gate_nxt[r_victim] = 1'b1;
      default:      w_gate_nxt = r_gate;
    endcase
  end

  // Allocator FSM with registered gate, note and ready outputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state    <= ALLOC_IDLE;
      r_ev_ready <= 1'b0;
      r_gate     <= '0;
      r_victim   <= '0;
      for (int v = 0; v < VOICES; v++) begin
        r_note[v] <= '0;
      end
`ifdef SUSTAIN_PEDAL_EN
      r_sus   <= '0;
      r_sus_d <= 1'b0;
`endif
    end else begin
      r_gate <= w_gate_nxt;
`ifdef SUSTAIN_PEDAL_EN
      r_sus   <= w_sus_nxt;
      r_sus_d <= i_sustain;
`endif
      case (r_state)
        ALLOC_IDLE: begin
          if (w_on_acc) begin
            r_note[w_alloc_idx] <= i_ev_note;
            if (w_alloc_two) begin
              r_state    <= ALLOC_RETRIG;
              r_victim   <= w_alloc_idx;
              r_ev_ready <= 1'b0;
            end else begin
              r_ev_ready <= 1'b1;
            end
          end else begin
            r_ev_ready <= 1'b1;
          end
        end
        ALLOC_RETRIG: begin
          r_state    <= ALLOC_IDLE;
          r_ev_ready <= 1'b1;
        end
        default: begin
          r_state    <= ALLOC_IDLE;
          r_ev_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator (VOICES=4): vector table plus reset,
// mid-steal reset and (with SUSTAIN_PEDAL_EN) sustain pedal sequences.
module tb_voice_allocator;
  import voice_allocator_pkg::*;

  localparam int VOICES = 4;
  localparam int NB     = 7;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   ev_valid;
  logic                   ev_ready;
  logic                   ev_note_on;
  logic [NB-1:0]          ev_note;
  logic [VOICES-1:0]      active;
  logic [VOICES-1:0]      gate;
  logic [VOICES*NB-1:0]   voice_note;
  logic                   sustain;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        valid;
    logic        on;
    logic [6:0]  note;
    logic [3:0]  act;
    logic [3:0]  exp_gate;
    logic        exp_ready;
    int          idx;
    logic [6:0]  exp_note;
  } vec_t;

  typedef struct {
    logic [3:0]  gate;
    logic        ready;
    int          idx;
    logic [6:0]  note;
    string       name;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[19];

  always #5 clk = ~clk;

  voice_allocator #(.VOICES(VOICES), .NOTE_BITS(NB)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_ev_valid   (ev_valid),
    .o_ev_ready   (ev_ready),
    .i_ev_note_on (ev_note_on),
    .i_ev_note    (ev_note),
    .i_active     (active),
    .o_gate       (gate),
    .o_voice_note (voice_note)
`ifdef SUSTAIN_PEDAL_EN
    ,
    .i_sustain    (sustain)
`endif
  );

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
    end
  endtask

  function automatic logic [6:0] vn(input int idx);
    return voice_note[idx*NB +: NB];
  endfunction

  // Drive one cycle of stimulus, queue the expectation, compare after the edge.
  task automatic step(input logic v, input logic on, input logic [6:0] note,
                      input logic [3:0] act, input exp_t e);
    exp_t got;
    ev_valid   = v;
    ev_note_on = on;
    ev_note    = note;
    active     = act;
    sb.push_back(e);
    @(posedge clk);
    #1;
    ev_valid = 1'b0;
    got = sb.pop_front();
    check({got.name, "_gate"},  32'(gate),       32'(got.gate));
    check({got.name, "_ready"}, 32'(ev_ready),   32'(got.ready));
    check({got.name, "_note"},  32'(vn(got.idx)), 32'(got.note));
  endtask

  function automatic exp_t mk(input logic [3:0] g, input logic r, input int idx,
                              input logic [6:0] n, input string name);
    exp_t e;
    e.gate = g; e.ready = r; e.idx = idx; e.note = n; e.name = name;
    return e;
  endfunction

  initial begin
    //         valid on    note   act      gate     rdy  idx note
    tbl[0]  = '{1'b1, 1'b1, 7'd60, 4'b0000, 4'b0001, 1'b1, 0, 7'd60};
    tbl[1]  = '{1'b1, 1'b1, 7'd64, 4'b0001, 4'b0011, 1'b1, 1, 7'd64};
    tbl[2]  = '{1'b1, 1'b1, 7'd62, 4'b0011, 4'b0111, 1'b1, 2, 7'd62};
    tbl[3]  = '{1'b1, 1'b1, 7'd65, 4'b0111, 4'b1111, 1'b1, 3, 7'd65};
    tbl[4]  = '{1'b1, 1'b1, 7'd67, 4'b1111, 4'b1110, 1'b0, 0, 7'd67};
    tbl[5]  = '{1'b0, 1'b0, 7'd0,  4'b1111, 4'b1111, 1'b1, 0, 7'd67};
    tbl[6]  = '{1'b1, 1'b0, 7'd62, 4'b1111, 4'b1011, 1'b1, 2, 7'd62};
    tbl[7]  = '{1'b1, 1'b1, 7'd70, 4'b1111, 4'b1111, 1'b1, 2, 7'd70};
    tbl[8]  = '{1'b1, 1'b0, 7'd99, 4'b1111, 4'b1111, 1'b1, 2, 7'd70};
    tbl[9]  = '{1'b1, 1'b1, 7'd64, 4'b1111, 4'b1101, 1'b0, 1, 7'd64};
    tbl[10] = '{1'b1, 1'b1, 7'd50, 4'b1111, 4'b1111, 1'b1, 3, 7'd65};
    tbl[11] = '{1'b1, 1'b1, 7'd72, 4'b1111, 4'b0111, 1'b0, 3, 7'd72};
    tbl[12] = '{1'b0, 1'b0, 7'd0,  4'b1111, 4'b1111, 1'b1, 3, 7'd72};
    tbl[13] = '{1'b1, 1'b0, 7'd72, 4'b1111, 4'b0111, 1'b1, 3, 7'd72};
    tbl[14] = '{1'b1, 1'b1, 7'd80, 4'b0111, 4'b1111, 1'b1, 3, 7'd80};
    tbl[15] = '{1'b1, 1'b0, 7'd67, 4'b1111, 4'b1110, 1'b1, 0, 7'd67};
    tbl[16] = '{1'b1, 1'b0, 7'd70, 4'b1111, 4'b1010, 1'b1, 2, 7'd70};
    tbl[17] = '{1'b1, 1'b1, 7'd81, 4'b1011, 4'b1110, 1'b1, 2, 7'd81};
    tbl[18] = '{1'b1, 1'b1, 7'd82, 4'b1111, 4'b1111, 1'b1, 0, 7'd82};

    reset = 1'b0; ev_valid = 1'b0; ev_note_on = 1'b0; ev_note = '0;
    active = '0; sustain = 1'b0;

    // Reset held for three edges.
    repeat (3) @(posedge clk);
    #1;
    check("rst_gate",  32'(gate),       32'h0);
    check("rst_notes", 32'(voice_note), 32'h0);
    check("rst_ready", 32'(ev_ready),   32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rel_ready", 32'(ev_ready), 32'h1);
    check("rel_gate",  32'(gate),     32'h0);

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].valid, tbl[i].on, tbl[i].note, tbl[i].act,
           mk(tbl[i].exp_gate, tbl[i].exp_ready, tbl[i].idx, tbl[i].exp_note,
              $sformatf("row%0d", i)));
    end

    // Steal in flight (oldest is voice 1), then reset during the RETRIG cycle.
    step(1'b1, 1'b1, 7'd90, 4'b1111, mk(4'b1101, 1'b0, 1, 7'd90, "steal90"));
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_gate",  32'(gate),     32'h0);
    check("midrst_ready", 32'(ev_ready), 32'h0);
    check("midrst_note",  32'(vn(1)),    32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_rel_ready", 32'(ev_ready), 32'h1);
    check("midrst_rel_gate",  32'(gate),     32'h0);

`ifdef SUSTAIN_PEDAL_EN
    sustain = 1'b1;
    step(1'b1, 1'b1, 7'd60, 4'b0000, mk(4'b0001, 1'b1, 0, 7'd60, "sus_on60"));
    step(1'b1, 1'b0, 7'd60, 4'b0001, mk(4'b0001, 1'b1, 0, 7'd60, "sus_off60"));
    step(1'b0, 1'b0, 7'd0,  4'b0001, mk(4'b0001, 1'b1, 0, 7'd60, "sus_hold"));
    sustain = 1'b0;
    step(1'b0, 1'b0, 7'd0,  4'b0001, mk(4'b0000, 1'b1, 0, 7'd60, "sus_release"));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
